// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port req/ack arbiter in front of a single-port data memory
//
// Purpose: shares one single-port memory between the CPU load/store path (port 0)
// and the debug/program loader (port 1). Each access runs IDLE -> ACCESS -> RESP.
// Arbitration is round-robin, or fixed priority to port 0 when PRIO0=1.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   r0_req/we/addr/wdata           port 0 request fields
//   r0_gnt, r0_ack                 port 0 ownership (ACCESS+RESP), completion pulse
//   r1_*                           port 1, same set as r0_*
//   rdata                          registered read data, valid while an ack is high
//   mem_write, m_addr, m_w_data    memory write strobe, address, write data
//   m_r_data                       memory read data (combinational from m_addr)
//   busy                           FSM not in IDLE

module mem_arbiter #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned PRIO0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_ack,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_write,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_w_data,
  input  logic [DW-1:0] m_r_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic          last_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          gnt0_q, gnt1_q;
  logic          ack0_q, ack1_q;
  logic          mem_write_q;
  logic          busy_q;

  logic          start_d;
  logic          owner_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Winner selection from the live requests; only consumed in IDLE.
  always_comb begin
    start_d = r0_req | r1_req;
    owner_d = 1'b0;
    if (r0_req && r1_req) begin
      // last_q resets to 1 so port 0 takes the first tie in round-robin mode.
      owner_d = (PRIO0 != 0) ? 1'b0 : ~last_q;
    end else begin
      owner_d = r1_req;
    end
    we_d    = owner_d ? r1_we    : r0_we;
    addr_d  = owner_d ? r1_addr  : r0_addr;
    wdata_d = owner_d ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          mem_write_q <= 1'b0;
          if (start_d) begin
            state_q     <= ACCESS;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt0_q      <= ~owner_d;
            gnt1_q      <= owner_d;
            // Strobe is registered here so it is high exactly for the ACCESS cycle.
            mem_write_q <= we_d;
            busy_q      <= 1'b1;
          end
        end
        ACCESS: begin
          mem_write_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= m_r_data;
          end
          ack0_q  <= ~owner_q;
          ack1_q  <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Address/data hold their last values outside ACCESS because they are the latch.
  assign m_addr    = addr_q;
  assign m_w_data  = wdata_q;
  assign mem_write = mem_write_q;
  assign rdata     = rdata_q;
  assign r0_gnt    = gnt0_q;
  assign r1_gnt    = gnt1_q;
  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_gnt, r0_ack, r1_gnt, r1_ack, mem_write, busy;
  logic [31:0] rdata, m_addr, m_w_data, m_r_data;

  logic        p_r0_req = 1'b0, p_r1_req = 1'b0;
  logic [31:0] p_r0_addr = '0, p_r1_addr = '0;
  logic        p_r0_gnt, p_r0_ack, p_r1_gnt, p_r1_ack, p_mem_write, p_busy;
  logic [31:0] p_rdata, p_m_addr, p_m_w_data, p_m_r_data;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .PRIO0(0)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_ack(r1_ack),
    .rdata(rdata), .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data),
    .m_r_data(m_r_data), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .PRIO0(1)) dut_p (
    .clk(clk), .rst(rst),
    .r0_req(p_r0_req), .r0_we(1'b0), .r0_addr(p_r0_addr), .r0_wdata(32'd0),
    .r0_gnt(p_r0_gnt), .r0_ack(p_r0_ack),
    .r1_req(p_r1_req), .r1_we(1'b0), .r1_addr(p_r1_addr), .r1_wdata(32'd0),
    .r1_gnt(p_r1_gnt), .r1_ack(p_r1_ack),
    .rdata(p_rdata), .mem_write(p_mem_write), .m_addr(p_m_addr), .m_w_data(p_m_w_data),
    .m_r_data(p_m_r_data), .busy(p_busy)
  );

  // Memory model: combinational read, write on the clock edge; 0x10 preloaded in reset.
  assign m_r_data   = mem[m_addr[7:0]];
  assign p_m_r_data = p_m_addr ^ 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h10] <= 32'h12345678;
    end else if (mem_write) begin
      mem[m_addr[7:0]] <= m_w_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic ep;

    // Reset state
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_r0_gnt", r0_gnt, 1'b0);
    chk1("rst_r1_ack", r1_ack, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_m_addr", m_addr, 32'h0);
    rst = 1'b1;

    // Port 0 read of 0x10
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    tick();
    chk1("rd0_c1_gnt", r0_gnt, 1'b1);
    chk1("rd0_c1_ack", r0_ack, 1'b0);
    chk1("rd0_c1_busy", busy, 1'b1);
    chk32("rd0_c1_addr", m_addr, 32'h10);
    chk1("rd0_c1_memwr", mem_write, 1'b0);
    tick();
    chk1("rd0_c2_gnt", r0_gnt, 1'b1);
    chk1("rd0_c2_ack", r0_ack, 1'b1);
    chk32("rd0_c2_rdata", rdata, 32'h12345678);
    chk1("rd0_c2_r1gnt", r1_gnt, 1'b0);
    r0_req = 1'b0;
    tick();
    chk1("rd0_c3_busy", busy, 1'b0);
    chk1("rd0_c3_gnt", r0_gnt, 1'b0);
    chk1("rd0_c3_ack", r0_ack, 1'b0);

    // Port 1 write 0xDEADBEEF to 0x20, then read it back
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'hDEADBEEF;
    tick();
    chk1("wr1_c1_memwr", mem_write, 1'b1);
    chk1("wr1_c1_gnt", r1_gnt, 1'b1);
    chk32("wr1_c1_wdata", m_w_data, 32'hDEADBEEF);
    tick();
    chk1("wr1_c2_memwr", mem_write, 1'b0);
    chk1("wr1_c2_ack", r1_ack, 1'b1);
    r1_we = 1'b0;
    tick();
    chk1("wr1_c3_busy", busy, 1'b0);
    chk1("wr1_c3_memwr", mem_write, 1'b0);
    chk32("wr1_mem", mem[8'h20], 32'hDEADBEEF);
    tick();
    chk1("rd1_c1_gnt", r1_gnt, 1'b1);
    tick();
    chk1("rd1_c2_ack", r1_ack, 1'b1);
    chk32("rd1_c2_rdata", rdata, 32'hDEADBEEF);
    r1_req = 1'b0;
    tick();
    chk1("rd1_c3_busy", busy, 1'b0);

    // Fresh reset, then tie: alternating grants 0,1,0,1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
    for (int t = 0; t < 4; t++) begin
      ep = (t % 2) == 1;
      tick();
      chk1("tie_gnt0", r0_gnt, ~ep);
      chk1("tie_gnt1", r1_gnt, ep);
      tick();
      chk1("tie_ack0", r0_ack, ~ep);
      chk1("tie_ack1", r1_ack, ep);
      chk32("tie_rdata", rdata, ep ? 32'hDEADBEEF : 32'h12345678);
      if (t == 3) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      tick();
    end
    chk1("tie_end_busy", busy, 1'b0);

    // Fixed priority instance: four held ties all go to port 0
    p_r0_req = 1'b1; p_r0_addr = 32'h44;
    p_r1_req = 1'b1; p_r1_addr = 32'h55;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk1("prio_gnt0", p_r0_gnt, 1'b1);
      chk1("prio_gnt1", p_r1_gnt, 1'b0);
      tick();
      chk1("prio_ack0", p_r0_ack, 1'b1);
      chk1("prio_ack1", p_r1_ack, 1'b0);
      chk32("prio_rdata", p_rdata, 32'hA5A5A5E1);
      if (t == 3) begin
        p_r0_req = 1'b0;
        p_r1_req = 1'b0;
      end
      tick();
      chk1("prio_idle_ack1", p_r1_ack, 1'b0);
    end
    chk1("prio_end_busy", p_busy, 1'b0);
    chk1("prio_memwr", p_mem_write, 1'b0);
    chk32("prio_wdata", p_m_w_data, 32'h0);

    // Reset asserted mid-ACCESS of a port 0 write
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h30; r0_wdata = 32'hCAFEF00D;
    tick();
    chk1("rstmid_memwr_pre", mem_write, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("rstmid_memwr", mem_write, 1'b0);
    chk1("rstmid_gnt", r0_gnt, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    r0_req = 1'b0; r0_we = 1'b0;
    tick();
    chk1("rstmid_noack", r0_ack, 1'b0);
    rst = 1'b1;
    tick();
    chk1("rstmid_noack2", r0_ack, 1'b0);
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h10;
    tick();
    chk1("rstmid_r1_gnt", r1_gnt, 1'b1);
    tick();
    chk1("rstmid_r1_ack", r1_ack, 1'b1);
    chk32("rstmid_r1_rdata", rdata, 32'h12345678);
    r1_req = 1'b0;
    tick();
    chk1("rstmid_idle", busy, 1'b0);

    // Early request drop: req high for a single cycle
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h20;
    tick();
    r0_req = 1'b0;
    chk1("drop_c1_gnt", r0_gnt, 1'b1);
    tick();
    chk1("drop_c2_ack", r0_ack, 1'b1);
    chk32("drop_c2_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk1("drop_c3_busy", busy, 1'b0);
    chk1("drop_c3_ack", r0_ack, 1'b0);
    tick();
    chk1("drop_c4_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
